// File: rtl/adam_aes_core_sequencer_pkg.sv
// Shared declarations for the AES core command sequencer.
// Opcodes, FSM state encoding and key-length constants.
package adam_aes_pkg;

  typedef enum logic [1:0] {
    OP_KEYINIT,
    OP_ENC,
    OP_DEC,
    OP_RSVD
  } aes_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KSTART,
    S_KWAIT,
    S_ESTART,
    S_EWAIT,
    S_DSTART,
    S_DWAIT,
    S_RESP
  } seq_state_e;

  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;

endpackage

// File: rtl/adam_aes_core_sequencer_if.sv
// Command / response channel between the register front-end
// and the AES command sequencer.
interface adam_aes_core_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_keylen;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_keylen, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_keylen, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err
  );
endinterface

// File: rtl/adam_aes_core_sequencer.sv
// AES command sequencer: starts key expansion / cipher engines,
// owns the shared S-box select and returns one response per command.
module adam_aes_core_sequencer
  import adam_aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  adam_aes_core_sequencer_if.slave cmd,
  output logic key_init,
  input  logic key_ready,
  output logic enc_next,
  input  logic enc_ready,
  output logic dec_next,
  input  logic dec_ready,
  output logic sbox_sel,
  output logic keylen,
  output logic key_valid,
  output logic busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  seq_state_e state, state_n;
  aes_op_e    op;

  logic            err_q, err_n;
  logic            kv_q, kv_n;
  logic            kl_q, kl_n;
  logic            key_init_q, enc_q, dec_q, sbox_q;
  logic            seen_low;
  logic [TO_W-1:0] wd, wd_inc;
  logic            start_st, wait_st;
  logic            eng_rdy, done, to_hit;

  assign op = aes_op_e'(cmd.cmd_op);

  assign start_st = (state == S_KSTART) |
                    (state == S_ESTART) |
                    (state == S_DSTART);
  assign wait_st  = (state == S_KWAIT) |
                    (state == S_EWAIT) |
                    (state == S_DWAIT);

  assign eng_rdy = ((state == S_KWAIT) & key_ready) |
                   ((state == S_EWAIT) & enc_ready) |
                   ((state == S_DWAIT) & dec_ready);

  // Completion needs a low sample first so a stale idle ready is not taken as done.
  assign done   = seen_low & eng_rdy;
  assign wd_inc = (wd == TO_MAX) ? wd : wd + TO_W'(1);
  assign to_hit = (wd_inc == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      err_q      <= 1'b0;
      kv_q       <= 1'b0;
      kl_q       <= KEYLEN_128;
      key_init_q <= 1'b0;
      enc_q      <= 1'b0;
      dec_q      <= 1'b0;
      sbox_q     <= 1'b0;
      seen_low   <= 1'b0;
      wd         <= '0;
    end else begin
      state      <= state_n;
      err_q      <= err_n;
      kv_q       <= kv_n;
      kl_q       <= kl_n;
      key_init_q <= (state_n == S_KSTART);
      enc_q      <= (state_n == S_ESTART);
      dec_q      <= (state_n == S_DSTART);
      sbox_q     <= (state_n == S_KSTART) |
                    (state_n == S_KWAIT);
      if (start_st) begin
        seen_low <= 1'b0;
        wd       <= '0;
      end else if (wait_st) begin
        if (!eng_rdy) seen_low <= 1'b1;
        wd <= wd_inc;
      end
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_q;
    kv_n    = kv_q;
    kl_n    = kl_q;
    unique case (state)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          unique case (1'b1)
            op == OP_KEYINIT: begin
              kl_n    = cmd.cmd_keylen;
              kv_n    = 1'b0;
              state_n = S_KSTART;
            end
            (op == OP_ENC) && kv_q: state_n = S_ESTART;
            (op == OP_DEC) && kv_q: state_n = S_DSTART;
            default: begin
              state_n = S_RESP;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      S_KSTART: state_n = S_KWAIT;
      S_ESTART: state_n = S_EWAIT;
      S_DSTART: state_n = S_DWAIT;
      S_KWAIT, S_EWAIT, S_DWAIT: begin
        if (done) begin
          state_n = S_RESP;
          err_n   = 1'b0;
          if (state == S_KWAIT) kv_n = 1'b1;
        end else if (to_hit) begin
          state_n = S_RESP;
          err_n   = 1'b1;
        end
      end
      S_RESP: begin
        if (cmd.rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = (state == S_IDLE);
    cmd.rsp_valid = (state == S_RESP);
    cmd.rsp_err   = err_q & (state == S_RESP);
    busy          = (state != S_IDLE);
    key_init      = key_init_q;
    enc_next      = enc_q;
    dec_next      = dec_q;
    sbox_sel      = sbox_q;
    keylen        = kl_q;
    key_valid     = kv_q;
  end

endmodule

// File: tb/tb_adam_aes_core_sequencer.sv
// Bench for the AES command sequencer: transaction-level timing
// model checked every cycle plus directed literal expectations.
module tb_adam_aes_core_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adam_aes_core_sequencer_if bus ();

  logic key_init, key_ready, enc_next, enc_ready;
  logic dec_next, dec_ready, sbox_sel, keylen;
  logic key_valid, busy;

  adam_aes_core_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus),
    .key_init  (key_init),
    .key_ready (key_ready),
    .enc_next  (enc_next),
    .enc_ready (enc_ready),
    .dec_next  (dec_next),
    .dec_ready (dec_ready),
    .sbox_sel  (sbox_sel),
    .keylen    (keylen),
    .key_valid (key_valid),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Engine behaviour: low for lat cycles after a start pulse, then idle.
  int k_lat = 1, e_lat = 1, d_lat = 1;
  int k_cnt = 0, e_cnt = 0, d_cnt = 0;
  bit k_go = 0, e_go = 0, d_go = 0;
  int kcnt = 0, ecnt = 0, dcnt = 0;

  always @(posedge clk) begin
    #1;
    if (k_go) begin
      k_go = 0; k_cnt = k_lat; key_ready = (k_lat == 0);
    end else if (k_cnt > 0) begin
      k_cnt--; if (k_cnt == 0) key_ready = 1'b1;
    end
    if (e_go) begin
      e_go = 0; e_cnt = e_lat; enc_ready = (e_lat == 0);
    end else if (e_cnt > 0) begin
      e_cnt--; if (e_cnt == 0) enc_ready = 1'b1;
    end
    if (d_go) begin
      d_go = 0; d_cnt = d_lat; dec_ready = (d_lat == 0);
    end else if (d_cnt > 0) begin
      d_cnt--; if (d_cnt == 0) dec_ready = 1'b1;
    end
  end

  // Transaction model: one command in flight, response time from engine latency.
  int cyc = 0;
  bit m_act = 0, m_err = 0, m_kv = 0, m_kl = 0;
  int m_eng = 0, t_acc = 0, t_rsp = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_kv = 0; m_kl = 0; m_eng = 0;
    end else begin
      int cur, n, lat;
      cur = cyc;
      if (m_act && cur >= t_rsp && bus.rsp_ready) begin
        if (m_eng == 1 && !m_err) m_kv = 1;
        m_act = 0;
      end else if (!m_act && bus.cmd_valid) begin
        n = cur + 1;
        m_act = 1; t_acc = n; m_eng = 0; lat = 0;
        case (bus.cmd_op)
          2'd0: begin
            m_kl = bus.cmd_keylen; m_kv = 0; m_eng = 1; lat = k_lat;
          end
          2'd1: if (m_kv) begin m_eng = 2; lat = e_lat; end
          2'd2: if (m_kv) begin m_eng = 3; lat = d_lat; end
          default: m_eng = 0;
        endcase
        if (m_eng == 0) begin
          t_rsp = n; m_err = 1;
        end else if (lat >= 1 && lat <= 63) begin
          t_rsp = n + 2 + lat; m_err = 0;
        end else begin
          t_rsp = n + 65; m_err = 1;
        end
      end
      cyc = cur + 1;
    end
  end

  bit run = 0;

  always @(negedge clk) begin
    if (!rst && run) begin
      int c;
      bit rv, kv;
      c  = cyc;
      rv = m_act && c >= t_rsp;
      kv = (m_act && m_eng == 1 && !m_err && c >= t_rsp) ? 1'b1 : m_kv;
      chk("cmd_ready", bus.cmd_ready, !m_act);
      chk("busy", busy, m_act);
      chk("rsp_valid", bus.rsp_valid, rv);
      if (rv) chk("rsp_err", bus.rsp_err, m_err);
      chk("key_init", key_init, m_act && m_eng == 1 && c == t_acc);
      chk("enc_next", enc_next, m_act && m_eng == 2 && c == t_acc);
      chk("dec_next", dec_next, m_act && m_eng == 3 && c == t_acc);
      chk("sbox_sel", sbox_sel, m_act && m_eng == 1 && c < t_rsp);
      chk("key_valid", key_valid, kv);
      chk("keylen", keylen, m_kl);
      chk("pulse_excl", 32'(key_init) + 32'(enc_next) + 32'(dec_next) <= 1, 1);
    end
    if (key_init) begin k_go = 1; kcnt++; end
    if (enc_next) begin e_go = 1; ecnt++; end
    if (dec_next) begin d_go = 1; dcnt++; end
  end

  task automatic start_cmd(input int op, input bit kl);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op[1:0];
    bus.cmd_keylen = kl;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic err, output int lat);
    lat = 0;
    err = 1'bx;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd3;
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input int op, input bit kl, input int hold,
                        output logic err, output int lat);
    start_cmd(op, kl);
    wait_rsp(hold, err, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    logic err;
    int   lat, k0, e0;
    int   lats [6] = '{1, 5, 30, 62, 0, 1000};
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_keylen = 0;
    bus.rsp_ready = 0;
    key_ready = 1; enc_ready = 1; dec_ready = 1;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_sbox", sbox_sel, 0);
    chk("rst_pulses", {key_init, enc_next, dec_next}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run = 1;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);

    do_cmd(1, 0, 0, err, lat);
    chk("enc_nokey_err", err, 1);
    chk("enc_nokey_lat", lat, 1);
    chk("enc_nokey_pulses", ecnt, 0);

    k_lat = 20;
    do_cmd(0, 1, 0, err, lat);
    chk("keyinit_err", err, 0);
    chk("keyinit_lat", lat, 23);
    chk("keyinit_pulses", kcnt, 1);
    @(negedge clk);
    chk("keyinit_kv", key_valid, 1);
    chk("keyinit_keylen", keylen, 1);

    e_lat = 40;
    do_cmd(1, 0, 0, err, lat);
    chk("enc40_err", err, 0);
    chk("enc40_lat", lat, 43);
    chk("enc40_pulses", ecnt, 1);

    d_lat = 1000;
    do_cmd(2, 0, 0, err, lat);
    chk("dec_to_err", err, 1);
    chk("dec_to_lat", lat, 66);
    @(negedge clk);
    chk("dec_to_kv", key_valid, 1);
    chk("dec_to_idle", busy, 0);

    e_lat = 62;
    do_cmd(1, 0, 0, err, lat);
    chk("enc62_err", err, 0);
    chk("enc62_lat", lat, 65);
    e_lat = 0;
    do_cmd(1, 0, 0, err, lat);
    chk("enc_noglitch_err", err, 1);
    chk("enc_noglitch_lat", lat, 66);
    do_cmd(3, 0, 0, err, lat);
    chk("rsvd_err", err, 1);
    chk("rsvd_lat", lat, 1);

    e_lat = 5;
    k0 = kcnt + ecnt + dcnt;
    do_cmd(1, 0, 10, err, lat);
    chk("hold_err", err, 0);
    chk("hold_lat", lat, 8);
    chk("hold_one_pulse", kcnt + ecnt + dcnt, k0 + 1);

    e_lat = 40;
    e0 = ecnt;
    start_cmd(1, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_kv", key_valid, 0);
    chk("arst_keylen", keylen, 0);
    chk("arst_sbox", sbox_sel, 0);
    chk("arst_pulses", {key_init, enc_next, dec_next}, 0);
    chk("arst_enc_started", ecnt, e0 + 1);
    @(posedge clk);
    #1 rst = 0;
    do_cmd(1, 0, 0, err, lat);
    chk("arst_enc_err", err, 1);
    chk("arst_enc_lat", lat, 1);

    for (int i = 0; i < 30; i++) begin
      int op;
      op    = int'($urandom_range(0, 3));
      k_lat = lats[$urandom_range(0, 5)];
      e_lat = lats[$urandom_range(0, 5)];
      d_lat = lats[$urandom_range(0, 5)];
      do_cmd(op, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), err, lat);
      if (op == 3) begin
        chk("rnd_rsvd_err", err, 1);
        chk("rnd_rsvd_lat", lat, 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
